hilo_mul_sequencer: RTL and testbench

Iterative multiply sequencer that owns the HI/LO register pair for the pipelined MIPS core. It executes MULTU and MADDU over multiple cycles with a shift-add datapath and serves MFHI/MFLO reads. While an operation is in flight it asserts a stall request so the pipeline holds any HI/LO instruction at issue. It sits beside the EX stage and is driven by the decode/issue logic.

---
 rtl/hilo_mul_sequencer.sv | 162 ++++++++++++++++
 tb/tb_hilo_mul_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_sequencer.sv
// hilo_mul_sequencer: iterative shift-add MULTU/MADDU unit that owns the MIPS HI/LO pair
// and serves MFHI/MFLO reads.
// Latency: a multiply occupies ITER+1 busy cycles after the accept edge.
//          MFHI/MFLO data is registered and appears 1 cycle after accept.
// Backpressure: stall = issue_valid & busy. Any op presented while busy is held
//               and is accepted in the first idle cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   issue_valid/op      HI/LO-class instruction: 00 MULTU, 01 MADDU, 10 MFHI, 11 MFLO
//   rs_val, rt_val      unsigned multiplicand / multiplier
//   stall, busy         hold request to issue; multiply in flight
//   rd_valid, rd_data   one-cycle read-result pulse and its data
//   hi, lo              architectural HI/LO
//
// Build option: define HILO_MUL_RADIX4_EN for a radix-4 datapath
// (2 multiplier bits per step, ITER = WIDTH/2). Radix-2 (ITER = WIDTH) is the default.

module hilo_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [1:0]       issue_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef HILO_MUL_RADIX4_EN
  localparam int ITER = WIDTH / 2;
  localparam int STEP = 2;
`else
  localparam int ITER = WIDTH;
  localparam int STEP = 1;
`endif
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   mcand;      // multiplicand, pre-shifted to the current bit position
  logic [PW-1:0]   prod;       // partial product
  logic [WIDTH-1:0] mplier;    // remaining multiplier bits, LSB consumed each step
  logic [CW-1:0]   cnt;
  logic            is_maddu;
  logic [PW-1:0]   addend;
  logic            accept;
  logic            mul_acc;
  logic            rd_acc;
`ifdef HILO_MUL_RADIX4_EN
  logic [PW-1:0]   mcand3;     // 3x multiplicand, formed once at accept
`endif

  assign accept  = issue_valid & ~busy;
  assign mul_acc = accept & ~issue_op[1];
  assign rd_acc  = accept &  issue_op[1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (mul_acc) state_nxt = S_RUN;
      S_RUN:    if (cnt == LAST) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy  = (state != S_IDLE);
    stall = issue_valid & busy;
  end

  // Per-step addend selected by the low multiplier bit(s)
  always_comb begin
    addend = '0;
`ifdef HILO_MUL_RADIX4_EN
    case (mplier[1:0])
      2'b01:   addend = mcand;
      2'b10:   addend = mcand << 1;
      2'b11:   addend = mcand3;
      default: addend = '0;
    endcase
`else
    if (mplier[0]) addend = mcand;
`endif
  end

  // Datapath and architectural state. Shifting mcand by STEP each cycle is
  // equivalent to adding it at the counter position, without a barrel shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand    <= '0;
      prod     <= '0;
      mplier   <= '0;
      cnt      <= '0;
      is_maddu <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef HILO_MUL_RADIX4_EN
      mcand3   <= '0;
`endif
    end else begin
      // Reads are only accepted in IDLE, so hi/lo are stable here.
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= issue_op[0] ? lo : hi;

      case (state)
        S_IDLE: begin
          if (mul_acc) begin
            mcand    <= {{WIDTH{1'b0}}, rs_val};
            mplier   <= rt_val;
            prod     <= '0;
            cnt      <= '0;
            is_maddu <= issue_op[0];
`ifdef HILO_MUL_RADIX4_EN
            mcand3   <= ({{WIDTH{1'b0}}, rs_val} << 1) + {{WIDTH{1'b0}}, rs_val};
`endif
          end
        end
        S_RUN: begin
          prod   <= prod + addend;
          mcand  <= mcand << STEP;
          mplier <= mplier >> STEP;
          cnt    <= cnt + CW'(1);
`ifdef HILO_MUL_RADIX4_EN
          mcand3 <= mcand3 << STEP;
`endif
        end
        S_COMMIT: begin
          // MADDU accumulates modulo 2^(2*WIDTH); carry out of HI is dropped.
          if (is_maddu) {hi, lo} <= {hi, lo} + prod;
          else          {hi, lo} <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// tb_hilo_mul_sequencer: directed self-checking bench for hilo_mul_sequencer (WIDTH=32).
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Backpressure: exercises stall by holding a read during a multiply.

module tb_hilo_mul_sequencer;

`ifdef HILO_MUL_RADIX4_EN
  localparam int ITER = 16;
`else
  localparam int ITER = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        stall, busy, rd_valid;
  logic [31:0] rd_data, hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_mul_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_op   (issue_op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .stall      (stall),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, wait for busy to drop, check busy length and hi:lo.
  task automatic do_mul(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cycles;
    logic [63:0] old;
    old = {hi, lo};
    issue_valid = 1'b1; issue_op = op; rs_val = a; rt_val = b;
    tick();
    issue_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (cycles == ITER + 1) check({tag, "_hold"}, {hi, lo}, old);
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(cycles), 64'(ITER + 1));
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    // Reset state
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    // Back-to-back reads after reset: MFHI then MFLO
    issue_valid = 1'b1; issue_op = 2'b10; tick();
    check("rst_mfhi_vld", {63'd0, rd_valid}, 64'd1);
    check("rst_mfhi_dat", {32'd0, rd_data}, 64'd0);
    issue_op = 2'b11; tick();
    issue_valid = 1'b0;
    check("rst_mflo_vld", {63'd0, rd_valid}, 64'd1);
    check("rst_mflo_dat", {32'd0, rd_data}, 64'd0);
    check("rst_rd_busy", {63'd0, busy}, 64'd0);
    tick();
    check("rd_pulse_end", {63'd0, rd_valid}, 64'd0);

    // MULTU wrap case
    do_mul("multu_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // Reads of a non-zero value, back-to-back
    issue_valid = 1'b1; issue_op = 2'b10; tick();
    check("mfhi_dat", {32'd0, rd_data}, 64'h0000_0000_FFFF_FFFE);
    issue_op = 2'b11; tick();
    issue_valid = 1'b0;
    check("mflo_vld", {63'd0, rd_valid}, 64'd1);
    check("mflo_dat", {32'd0, rd_data}, 64'd1);

    // MADDU accumulation, then build all-ones, then wrap to zero
    do_mul("maddu_2x3", 2'b01, 32'd2, 32'd3, 64'hFFFF_FFFE_0000_0007);
    do_mul("maddu_fill", 2'b01, 32'hFFFF_FFFC, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    do_mul("maddu_wrap", 2'b01, 32'd1, 32'd1, 64'd0);

    // Stalled read: MFLO held during MULTU 7x6
    begin
      int stall_cnt;
      int guard;
      issue_valid = 1'b1; issue_op = 2'b00; rs_val = 32'd7; rt_val = 32'd6;
      tick();
      issue_op = 2'b11;  // MFLO presented immediately while busy
      stall_cnt = 0;
      guard = 0;
      while (busy && guard < 200) begin
        guard++;
        if (stall) stall_cnt++;
        tick();
      end
      check("stall_cycles", 64'(stall_cnt), 64'(ITER + 1));
      check("stall_idle_low", {63'd0, stall}, 64'd0);
      tick();
      issue_valid = 1'b0;
      check("stalled_rd_vld", {63'd0, rd_valid}, 64'd1);
      check("stalled_rd_dat", {32'd0, rd_data}, 64'd42);
      tick();
      check("stalled_rd_once", {63'd0, rd_valid}, 64'd0);
    end

    // Reset in RUN cycle 10 of MULTU 5x5
    issue_valid = 1'b1; issue_op = 2'b00; rs_val = 32'd5; rt_val = 32'd5;
    tick();
    issue_valid = 1'b0;
    repeat (9) tick();
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    check("mid_rst_rd_data", {32'd0, rd_data}, 64'd0);
    repeat (ITER + 5) tick();
    check("mid_rst_no_commit", {hi, lo}, 64'd0);
    check("mid_rst_idle", {63'd0, busy}, 64'd0);

    // Reset vs simultaneous issue
    do_mul("multu_2x2", 2'b00, 32'd2, 32'd2, 64'd4);
    rst = 1'b1; issue_valid = 1'b1; issue_op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
    tick();
    rst = 1'b0; issue_valid = 1'b0;
    check("rvi_busy", {63'd0, busy}, 64'd0);
    check("rvi_hilo", {hi, lo}, 64'd0);
    repeat (ITER + 3) tick();
    check("rvi_busy_later", {63'd0, busy}, 64'd0);
    check("rvi_hilo_later", {hi, lo}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
